// File: rtl/rounded_shift_mult_pipe_pkg.sv
// Shared constants for the power-of-two rounded multiplier datapath.
// Holds the default operand widths and the derived shift and product widths.
package rounded_shift_mult_pipe_pkg;

   localparam int unsigned WIDTH_DEF      = 16;
   localparam int unsigned LOG2_WIDTH_DEF = 4;
   localparam int unsigned SH_W           = LOG2_WIDTH_DEF + 1;
   localparam int unsigned P_W            = 2 * WIDTH_DEF;

endpackage

// File: rtl/rounded_shift_mult_pipe_if.sv
// Valid/ready bundle between the operand-rounding stage, the shift multiplier and the accumulator.
// The producer/consumer side uses master; the multiplier uses slave.
interface rounded_shift_mult_pipe_if
   import rounded_shift_mult_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
);

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH:0]     A_r;
   logic [WIDTH-1:0]   B;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] P;
   logic               err;

   modport master (
      output in_valid, A_r, B, out_ready,
      input  in_ready, out_valid, P, err
   );

   modport slave (
      input  in_valid, A_r, B, out_ready,
      output in_ready, out_valid, P, err
   );

endinterface

// File: rtl/rounded_shift_mult_pipe_onehot_to_shamt.sv
// Combinational priority encoder: index of the highest set bit plus an all-zero flag.
// A non-one-hot input resolves to its highest set bit.
module rounded_shift_mult_pipe_onehot_to_shamt
   import rounded_shift_mult_pipe_pkg::*;
#(
   parameter int unsigned IN_W  = WIDTH_DEF + 1,
   parameter int unsigned OUT_W = SH_W
) (
   input  logic [IN_W-1:0]  onehot_i,
   output logic [OUT_W-1:0] shamt_o,
   output logic             zero_o
);

   // Ascending scan so the highest set bit wins.
   always_comb begin
      shamt_o = '0;
      for (int i = 0; i < int'(IN_W); i++) begin
         if (onehot_i[i]) begin
            shamt_o = OUT_W'(i);
         end
      end
   end

   assign zero_o = ~|onehot_i;

endmodule

// File: rtl/rounded_shift_mult_pipe.sv
// Two-stage valid/ready approximate multiplier: P = B << log2(A_r), with A_r a rounded power of two.
// Define ROUNDED_MULT_ONEHOT_CHECK_EN to flag A_r values that are neither one-hot nor zero on err.
module rounded_shift_mult_pipe
   import rounded_shift_mult_pipe_pkg::*;
#(
   parameter int unsigned WIDTH      = WIDTH_DEF,
   parameter int unsigned LOG2_WIDTH = LOG2_WIDTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   rounded_shift_mult_pipe_if.slave bus
);

   localparam int unsigned SH_BITS = LOG2_WIDTH + 1;
   localparam int unsigned P_BITS  = 2 * WIDTH;

   logic               vld_p1_q, vld_p1_d;
   logic               vld_p2_q, vld_p2_d;
   logic               adv_p1, adv_p2, acc_p0;
   logic [SH_BITS-1:0] sh_p0;
   logic               z_p0;
   logic [WIDTH-1:0]   b_p1_q;
   logic [SH_BITS-1:0] sh_p1_q;
   logic               z_p1_q;
   logic [P_BITS-1:0]  p_p2_q, p_p2_d;

   // Ready propagates combinationally from out_ready; there is no skid buffer.
   assign adv_p2       = !vld_p2_q || bus.out_ready;
   assign adv_p1       = !vld_p1_q || adv_p2;
   assign acc_p0       = bus.in_valid && adv_p1;
   assign bus.in_ready = adv_p1;

   // ---- stage 0 -> 1: encode A_r into a shift amount ----
   rounded_shift_mult_pipe_onehot_to_shamt #(
      .IN_W  (WIDTH + 1),
      .OUT_W (SH_BITS)
   ) u_enc (
      .onehot_i (bus.A_r),
      .shamt_o  (sh_p0),
      .zero_o   (z_p0)
   );

   always_comb begin
      vld_p1_d = vld_p1_q;
      vld_p2_d = vld_p2_q;
      if (adv_p1) vld_p1_d = bus.in_valid;
      if (adv_p2) vld_p2_d = vld_p1_q;
      p_p2_d = z_p1_q ? '0 : (P_BITS'(b_p1_q) << sh_p1_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
      end else begin
         vld_p1_q <= vld_p1_d;
         vld_p2_q <= vld_p2_d;
      end
   end

   always_ff @(posedge clk) begin
      if (acc_p0) begin
         b_p1_q  <= bus.B;
         sh_p1_q <= sh_p0;
         z_p1_q  <= z_p0;
      end
   end

   // ---- stage 1 -> 2: shift; P only moves when real data arrives ----
   always_ff @(posedge clk) begin
      if (rst) begin
         p_p2_q <= '0;
      end else if (adv_p2 && vld_p1_q) begin
         p_p2_q <= p_p2_d;
      end
   end

   assign bus.out_valid = vld_p2_q;
   assign bus.P         = p_p2_q;

`ifdef ROUNDED_MULT_ONEHOT_CHECK_EN
   logic bad_p0, bad_p1_q, bad_p2_q;

   assign bad_p0 = |(bus.A_r & (bus.A_r - (WIDTH + 1)'(1)));

   always_ff @(posedge clk) begin
      if (acc_p0) begin
         bad_p1_q <= bad_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bad_p2_q <= 1'b0;
      end else if (adv_p2 && vld_p1_q) begin
         bad_p2_q <= bad_p1_q;
      end
   end

   assign bus.err = bad_p2_q;
`else
   assign bus.err = 1'b0;
`endif

endmodule
